dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 22 ++
 rtl/dmem_arb_rr.sv | 21 ++
 rtl/dmem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared widths and enums for the data-memory arbiter.
//   DATA_W / ADDR_W / LEN_W : data, address and burst-length widths
//   state_e                 : arbiter FSM states
//   grant_e                 : round-robin grant owner
package dmem_arb_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned LEN_W  = 4;

    typedef enum logic [1:0] {
        StIdle,
        StVec,
        StDone
    } state_e;

    typedef enum logic {
        GNT_CPU,
        GNT_VEC
    } grant_e;

endpackage

// File: rtl/dmem_arb_rr.sv
// dmem_arb_rr: two-way round-robin selector.
//   cpu_req_i / vec_req_i : requests
//   last_grant_i          : owner of the previous grant
//   gnt_cpu_o / gnt_vec_o : one-hot (or zero) grant
// A lone requester always wins; on contention the side that did not win last time is chosen.
module dmem_arb_rr
    import dmem_arb_pkg::*;
(
    input  logic   cpu_req_i,
    input  logic   vec_req_i,
    input  grant_e last_grant_i,
    output logic   gnt_cpu_o,
    output logic   gnt_vec_o
);

    always_comb begin
        gnt_cpu_o = cpu_req_i & (~vec_req_i | (last_grant_i == GNT_VEC));
        gnt_vec_o = vec_req_i & (~cpu_req_i | (last_grant_i == GNT_CPU));
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port synchronous-read RAM between the CPU MEM stage and a
// vector unit issuing fixed-length bursts.
//   clk, rst                         : clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata/rdata/stall: CPU single-cycle access port
//   vec_req/we/base/len/wdata        : burst request (len = beats - 1)
//   vec_wready/rdata/rvalid/done     : burst beat handshake and completion pulse
//   mem_we/addr/wdata/rdata          : RAM port (read data one cycle after address)
// Optional macro DMEM_ARB_PREEMPT_EN: a pending CPU request may steal one cycle between vector
// beats; without it bursts are atomic.
module dmem_arbiter
    import dmem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              vec_req,
    input  logic              vec_we,
    input  logic [ADDR_W-1:0] vec_base,
    input  logic [LEN_W-1:0]  vec_len,
    input  logic [DATA_W-1:0] vec_wdata,
    output logic              vec_wready,
    output logic [DATA_W-1:0] vec_rdata,
    output logic              vec_rvalid,
    output logic              vec_done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q, state_d;
    grant_e            last_grant_q, last_grant_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              we_q, we_d;
    logic              rd_pending_q, rd_pending_d;
`ifdef DMEM_ARB_PREEMPT_EN
    // Set after a stolen CPU cycle so the next VEC cycle is guaranteed to be a beat.
    logic              cpu_slot_q, cpu_slot_d;
`endif

    logic rr_gnt_cpu, rr_gnt_vec;
    logic cpu_gnt, beat;

    // Requests are masked in reset so no grant (and no RAM write) can leak out while rst is low.
    dmem_arb_rr u_rr (
        .cpu_req_i    (cpu_req & rst),
        .vec_req_i    (vec_req & rst),
        .last_grant_i (last_grant_q),
        .gnt_cpu_o    (rr_gnt_cpu),
        .gnt_vec_o    (rr_gnt_vec)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        base_d       = base_q;
        len_d        = len_q;
        we_d         = we_q;
`ifdef DMEM_ARB_PREEMPT_EN
        cpu_slot_d   = cpu_slot_q;
`endif
        cpu_gnt      = 1'b0;
        beat         = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = cpu_addr;
        mem_wdata    = cpu_wdata;
        vec_wready   = 1'b0;
        vec_done     = 1'b0;

        case (state_q)
            StIdle: begin
                if (rr_gnt_cpu) begin
                    cpu_gnt      = 1'b1;
                    mem_we       = cpu_we;
                    last_grant_d = GNT_CPU;
                end else if (rr_gnt_vec) begin
                    base_d       = vec_base;
                    len_d        = vec_len;
                    we_d         = vec_we;
                    beat_cnt_d   = '0;
                    last_grant_d = GNT_VEC;
                    state_d      = StVec;
`ifdef DMEM_ARB_PREEMPT_EN
                    cpu_slot_d   = 1'b0;
`endif
                end
            end
            StVec: begin
`ifdef DMEM_ARB_PREEMPT_EN
                if (cpu_req && !cpu_slot_q) begin
                    cpu_gnt    = 1'b1;
                    mem_we     = cpu_we;
                    cpu_slot_d = 1'b1;
                end else begin
                    beat       = 1'b1;
                    cpu_slot_d = 1'b0;
                end
`else
                beat = 1'b1;
`endif
                if (beat) begin
                    mem_addr   = base_q + ADDR_W'(beat_cnt_q);
                    mem_we     = we_q;
                    mem_wdata  = vec_wdata;
                    vec_wready = we_q;
                    if (beat_cnt_q == len_q) begin
                        state_d = StDone;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            StDone: begin
                vec_done = 1'b1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        rd_pending_d = beat & ~we_q;
        cpu_stall    = cpu_req & ~cpu_gnt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            last_grant_q <= GNT_VEC;
            beat_cnt_q   <= '0;
            base_q       <= '0;
            len_q        <= '0;
            we_q         <= 1'b0;
            rd_pending_q <= 1'b0;
`ifdef DMEM_ARB_PREEMPT_EN
            cpu_slot_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            base_q       <= base_d;
            len_q        <= len_d;
            we_q         <= we_d;
            rd_pending_q <= rd_pending_d;
`ifdef DMEM_ARB_PREEMPT_EN
            cpu_slot_q   <= cpu_slot_d;
`endif
        end
    end

    assign cpu_rdata  = mem_rdata;
    assign vec_rdata  = mem_rdata;
    assign vec_rvalid = rd_pending_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed, scoreboard-checked bench for dmem_arbiter with a RAM model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        vec_req, vec_we;
    logic [15:0] vec_base, vec_wdata, vec_rdata;
    logic [3:0]  vec_len;
    logic        vec_wready, vec_rvalid, vec_done;
    logic        mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    logic [15:0] ram [0:65535];
    logic [15:0] shadow [logic [15:0]];
    logic [15:0] cpu_q [$];
    logic [15:0] rd_q [$];
    logic [15:0] addr_q [$];

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    dmem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .vec_req    (vec_req),
        .vec_we     (vec_we),
        .vec_base   (vec_base),
        .vec_len    (vec_len),
        .vec_wdata  (vec_wdata),
        .vec_wready (vec_wready),
        .vec_rdata  (vec_rdata),
        .vec_rvalid (vec_rvalid),
        .vec_done   (vec_done),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        sample();
        chk("cw_we", mem_we, 1'b1);
        chk("cw_addr", mem_addr, a);
        chk("cw_stall", cpu_stall, 1'b0);
        shadow[a] = d;
        tick();
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic vec_write_burst(input logic [15:0] base, input logic [3:0] len);
        logic [15:0] a, d;
        vec_req = 1'b1; vec_we = 1'b1; vec_base = base; vec_len = len;
        for (int i = 0; i <= int'(len); i++) addr_q.push_back(base + 16'(i));
        sample();
        chk("vw_grant_we", mem_we, 1'b0);
        chk("vw_grant_wready", vec_wready, 1'b0);
        tick();
        // Changes after the grant must be ignored.
        vec_req = 1'b0; vec_we = 1'b0; vec_base = 16'hDEAD; vec_len = 4'd0;
        for (int i = 0; i <= int'(len); i++) begin
            d = 16'h3000 + base + 16'(i);
            vec_wdata = d;
            sample();
            a = addr_q.pop_front();
            chk("vw_addr", mem_addr, a);
            chk("vw_we", mem_we, 1'b1);
            chk("vw_wready", vec_wready, 1'b1);
            chk("vw_wdata", mem_wdata, d);
            chk("vw_done_early", vec_done, 1'b0);
            shadow[a] = d;
            tick();
        end
        sample();
        chk("vw_done", vec_done, 1'b1);
        chk("vw_done_we", mem_we, 1'b0);
        chk("vw_done_wready", vec_wready, 1'b0);
        tick();
        sample();
        chk("vw_done_pulse", vec_done, 1'b0);
        tick();
    endtask

    task automatic vec_read_burst(input logic [15:0] base, input logic [3:0] len);
        logic [15:0] a;
        vec_req = 1'b1; vec_we = 1'b0; vec_base = base; vec_len = len;
        sample();
        chk("vr_grant_we", mem_we, 1'b0);
        chk("vr_grant_rvalid", vec_rvalid, 1'b0);
        tick();
        vec_req = 1'b0; vec_we = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            a = base + 16'(i);
            sample();
            chk("vr_addr", mem_addr, a);
            chk("vr_we", mem_we, 1'b0);
            chk("vr_wready", vec_wready, 1'b0);
            if (i == 0) chk("vr_rvalid0", vec_rvalid, 1'b0);
            else begin
                chk("vr_rvalid", vec_rvalid, 1'b1);
                chk("vr_rdata", vec_rdata, rd_q.pop_front());
            end
            rd_q.push_back(shadow[a]);
            tick();
        end
        sample();
        chk("vr_done", vec_done, 1'b1);
        chk("vr_last_rvalid", vec_rvalid, 1'b1);
        chk("vr_last_rdata", vec_rdata, rd_q.pop_front());
        tick();
        sample();
        chk("vr_rvalid_end", vec_rvalid, 1'b0);
        tick();
        vec_we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "simulation timeout");
    end

    initial begin
        rst = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0000; cpu_wdata = 16'h1111;
        vec_req = 1'b0; vec_we = 1'b0; vec_base = '0; vec_len = '0; vec_wdata = '0;
        #3;
        chk("rst_stall", cpu_stall, 1'b1);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_wready", vec_wready, 1'b0);
        chk("rst_rvalid", vec_rvalid, 1'b0);
        chk("rst_done", vec_done, 1'b0);
        #4;
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
        tick();

        // CPU write then read back.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0000; cpu_wdata = 16'h5678;
        sample();
        chk("c1_we", mem_we, 1'b1);
        chk("c1_addr", mem_addr, 16'h0000);
        chk("c1_wdata", mem_wdata, 16'h5678);
        chk("c1_stall", cpu_stall, 1'b0);
        shadow[16'h0000] = 16'h5678;
        tick();
        cpu_we = 1'b0;
        cpu_q.push_back(shadow[16'h0000]);
        sample();
        chk("c2_we", mem_we, 1'b0);
        chk("c2_addr", mem_addr, 16'h0000);
        chk("c2_stall", cpu_stall, 1'b0);
        tick();
        cpu_req = 1'b0;
        sample();
        chk("c3_rdata", cpu_rdata, cpu_q.pop_front());
        chk("c3_we", mem_we, 1'b0);
        tick();

        // Vector write burst at 0x0010, four beats.
        vec_write_burst(16'h0010, 4'd3);

`ifndef DMEM_ARB_PREEMPT_EN
        // Simultaneous requests straight out of reset: CPU first, then the burst.
        @(negedge clk);
        rst = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        vec_req = 1'b1; vec_we = 1'b0; vec_base = 16'h0010; vec_len = 4'd1;
        #2;
        rst = 1'b1;
        #1;
        chk("s0_stall", cpu_stall, 1'b0);
        chk("s0_addr", mem_addr, 16'h0010);
        cpu_q.push_back(shadow[16'h0010]);
        tick();
        sample();
        chk("s1_stall", cpu_stall, 1'b1);
        chk("s1_we", mem_we, 1'b0);
        chk("s1_cpu_rdata", cpu_rdata, cpu_q.pop_front());
        tick();
        sample();
        chk("s2_addr", mem_addr, 16'h0010);
        chk("s2_stall", cpu_stall, 1'b1);
        chk("s2_rvalid", vec_rvalid, 1'b0);
        rd_q.push_back(shadow[16'h0010]);
        tick();
        sample();
        chk("s3_addr", mem_addr, 16'h0011);
        chk("s3_stall", cpu_stall, 1'b1);
        chk("s3_rvalid", vec_rvalid, 1'b1);
        chk("s3_rdata", vec_rdata, rd_q.pop_front());
        rd_q.push_back(shadow[16'h0011]);
        tick();
        sample();
        chk("s4_done", vec_done, 1'b1);
        chk("s4_stall", cpu_stall, 1'b1);
        chk("s4_rvalid", vec_rvalid, 1'b1);
        chk("s4_rdata", vec_rdata, rd_q.pop_front());
        tick();
        sample();
        chk("s5_cpu_wins", cpu_stall, 1'b0);
        chk("s5_addr", mem_addr, 16'h0010);
        chk("s5_done", vec_done, 1'b0);
        tick();
        cpu_req = 1'b0; vec_req = 1'b0;
        tick();
`endif

        // Read burst wrapping past the top of the address space.
        cpu_write(16'hFFFF, 16'hBEEF);
        vec_read_burst(16'hFFFF, 4'd1);

        // Reset during beat 2 of an eight-beat write burst.
        vec_req = 1'b1; vec_we = 1'b1; vec_base = 16'h0100; vec_len = 4'd7;
        sample();
        tick();
        vec_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vec_wdata = 16'h7700 + 16'(i);
            sample();
            chk("ra_addr", mem_addr, 16'h0100 + 16'(i));
            chk("ra_we", mem_we, 1'b1);
            if (i < 2) begin
                shadow[16'h0100 + 16'(i)] = vec_wdata;
                tick();
            end
        end
        #1;
        rst = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 16'h4444;
        #1;
        chk("ra_rst_we", mem_we, 1'b0);
        chk("ra_rst_wready", vec_wready, 1'b0);
        chk("ra_rst_done", vec_done, 1'b0);
        chk("ra_rst_rvalid", vec_rvalid, 1'b0);
        chk("ra_rst_stall", cpu_stall, 1'b1);
        cpu_req = 1'b0; cpu_we = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sample();
            chk("ra_no_done", vec_done, 1'b0);
            chk("ra_no_beat", mem_we, 1'b0);
            tick();
        end
        cpu_write(16'h0050, 16'h5050);

`ifdef DMEM_ARB_PREEMPT_EN
        begin
            int beats, dones, cpu_slots;
            logic prev_cpu, in_burst;
            beats = 0; dones = 0; cpu_slots = 0; prev_cpu = 1'b0; in_burst = 1'b1;
            vec_req = 1'b1; vec_we = 1'b1; vec_base = 16'h0200; vec_len = 4'd3;
            for (int i = 0; i < 4; i++) addr_q.push_back(16'h0200 + 16'(i));
            sample();
            chk("p_grant_we", mem_we, 1'b0);
            tick();
            vec_req = 1'b0;
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0000;
            for (int c = 0; c < 14; c++) begin
                vec_wdata = 16'h9200 + 16'(beats);
                sample();
                if (vec_wready) begin
                    chk("p_beat_addr", mem_addr, addr_q.pop_front());
                    chk("p_beat_we", mem_we, 1'b1);
                    chk("p_beat_inburst", in_burst, 1'b1);
                    beats++;
                    prev_cpu = 1'b0;
                end else if (in_burst && !cpu_stall) begin
                    chk("p_one_cpu_slot", prev_cpu, 1'b0);
                    chk("p_cpu_addr", mem_addr, 16'h0000);
                    cpu_slots++;
                    prev_cpu = 1'b1;
                end
                if (vec_done) begin
                    dones++;
                    in_burst = 1'b0;
                end
                tick();
            end
            cpu_req = 1'b0;
            chk("p_beats", beats, 4);
            chk("p_dones", dones, 1);
            chk("p_cpu_slots", cpu_slots, 4);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
